// File: rtl/rotaciona_linhas_seq.sv
// rotaciona_linhas_seq
//
// Iterative row-rotation stage between the substitution and column-mix stages.
// Row r of the state ends up rotated by (r mod COLUNAS) bytes. One shared byte
// shifter does one single-byte step per clock. Blocks enter and leave through
// valid/ready handshakes.
//
// Optional build macro ROTACIONA_INVERSA_EN: when defined, modo=1 selects right
// rotation (decipher path). When undefined, modo is ignored, every block is
// rotated left, and no right-step logic exists.
//
// Ports:
//   clk            clock, rising edge
//   rst_n          synchronous active-low reset
//   entrada_valida input block/mode valid
//   entrada_pronta block can be accepted (idle and not in reset)
//   bloco          input state, row 0 in the MSBs, byte 0 = MSB of each row
//   modo           0 = rotate left, 1 = rotate right (only with the macro)
//   saida_valida   saida holds a finished result
//   saida_pronta   downstream accepts the result
//   saida          rotated state, held after the handshake until the next result
//   ocupado        a block is being rotated or waits to be delivered
//
// estado    | meaning
// OCIOSO    | waiting for an input block
// ROTACIONA | one byte step per clock on every row still short of its amount
// CONCLUIDO | result on saida, waiting for saida_pronta

module rotaciona_linhas_seq #(
    parameter int LINHAS       = 4,
    parameter int COLUNAS      = 4,
    parameter int LARGURA_BYTE = 8
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    entrada_valida,
    output logic                                    entrada_pronta,
    input  logic [LINHAS*COLUNAS*LARGURA_BYTE-1:0]  bloco,
    input  logic                                    modo,
    output logic                                    saida_valida,
    input  logic                                    saida_pronta,
    output logic [LINHAS*COLUNAS*LARGURA_BYTE-1:0]  saida,
    output logic                                    ocupado
);

    localparam int LARG_LINHA = COLUNAS * LARGURA_BYTE;
    localparam int LARG       = LINHAS * LARG_LINHA;
    localparam int CW         = (LINHAS > 1) ? $clog2(LINHAS) : 1;
    localparam int ULT        = (LINHAS > 1) ? LINHAS - 2 : 0;
    localparam logic [CW-1:0] CNT_ULT = CW'(ULT);

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        ROTACIONA = 2'd1,
        CONCLUIDO = 2'd2
    } estado_t;

    estado_t            estado;
    estado_t            estado_prox;
    logic [CW-1:0]      cnt;
    logic [LARG-1:0]    dados;
    logic [LARG-1:0]    dados_passo;

`ifdef ROTACIONA_INVERSA_EN
    logic               modo_reg;
`else
    logic               unused_modo;
    assign unused_modo = modo;
`endif

    // Shifts written as shift/or so a single-byte row (COLUNAS=1) degenerates
    // to the identity instead of an empty part-select.
    function automatic logic [LARG_LINHA-1:0] passo_esq(input logic [LARG_LINHA-1:0] l);
        return (l << LARGURA_BYTE) | (l >> (LARG_LINHA - LARGURA_BYTE));
    endfunction

`ifdef ROTACIONA_INVERSA_EN
    function automatic logic [LARG_LINHA-1:0] passo_dir(input logic [LARG_LINHA-1:0] l);
        return (l >> LARGURA_BYTE) | (l << (LARG_LINHA - LARGURA_BYTE));
    endfunction
`endif

    // Row r keeps stepping while cnt < r, so after LINHAS-1 steps it has
    // moved exactly r bytes; row 0 is never touched.
    always_comb begin
        dados_passo = dados;
        for (int r = 1; r < LINHAS; r++) begin
            if (r > int'(cnt)) begin
`ifdef ROTACIONA_INVERSA_EN
                dados_passo[LARG-1-r*LARG_LINHA -: LARG_LINHA] = modo_reg
                    ? passo_dir(dados[LARG-1-r*LARG_LINHA -: LARG_LINHA])
                    : passo_esq(dados[LARG-1-r*LARG_LINHA -: LARG_LINHA]);
`else
                dados_passo[LARG-1-r*LARG_LINHA -: LARG_LINHA] =
                    passo_esq(dados[LARG-1-r*LARG_LINHA -: LARG_LINHA]);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    always_comb begin
        estado_prox    = estado;
        entrada_pronta = 1'b0;
        ocupado        = 1'b0;
        case (estado)
            OCIOSO: begin
                entrada_pronta = rst_n;
                if (entrada_valida) begin
                    estado_prox = (LINHAS > 1) ? ROTACIONA : CONCLUIDO;
                end
            end
            ROTACIONA: begin
                ocupado = 1'b1;
                if (cnt == CNT_ULT) begin
                    estado_prox = CONCLUIDO;
                end
            end
            CONCLUIDO: begin
                ocupado = 1'b1;
                if (saida_pronta) begin
                    estado_prox = OCIOSO;
                end
            end
            default: begin
                estado_prox = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt          <= '0;
            dados        <= '0;
            saida        <= '0;
            saida_valida <= 1'b0;
`ifdef ROTACIONA_INVERSA_EN
            modo_reg     <= 1'b0;
`endif
        end else begin
            case (estado)
                OCIOSO: begin
                    if (entrada_valida) begin
                        dados <= bloco;
                        cnt   <= '0;
`ifdef ROTACIONA_INVERSA_EN
                        modo_reg <= modo;
`endif
                        // A single-row state needs no rotation at all.
                        if (LINHAS == 1) begin
                            saida        <= bloco;
                            saida_valida <= 1'b1;
                        end
                    end
                end
                ROTACIONA: begin
                    dados <= dados_passo;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_ULT) begin
                        saida        <= dados_passo;
                        saida_valida <= 1'b1;
                    end
                end
                CONCLUIDO: begin
                    if (saida_pronta) begin
                        saida_valida <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotaciona_linhas_seq.sv
module tb_rotaciona_linhas_seq;

    localparam logic [127:0] V1 = 128'h50564543415253494c41544641544552;
    localparam logic [127:0] L1 = 128'h505645435253494154464c4152415445;
    localparam logic [127:0] V5 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] L5 = 128'h0001020304050607090a0b0c0d0e0f08;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         entrada_valida = 1'b0;
    logic         modo = 1'b0;
    logic         saida_pronta = 1'b1;
    logic [127:0] bloco = '0;

    logic         entrada_pronta0, saida_valida0, ocupado0;
    logic [127:0] saida0;
    logic         entrada_pronta1, saida_valida1, ocupado1;
    logic [127:0] saida1;

    int testes = 0;
    int falhas = 0;
    int cyc = 0;

    // Both instances see the same stimulus; the model tracks each separately.
    rotaciona_linhas_seq #(.LINHAS(4), .COLUNAS(4), .LARGURA_BYTE(8)) dut (
        .clk(clk), .rst_n(rst_n), .entrada_valida(entrada_valida),
        .entrada_pronta(entrada_pronta0), .bloco(bloco), .modo(modo),
        .saida_valida(saida_valida0), .saida_pronta(saida_pronta),
        .saida(saida0), .ocupado(ocupado0));

    rotaciona_linhas_seq #(.LINHAS(2), .COLUNAS(8), .LARGURA_BYTE(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .entrada_valida(entrada_valida),
        .entrada_pronta(entrada_pronta1), .bloco(bloco), .modo(modo),
        .saida_valida(saida_valida1), .saida_pronta(saida_pronta),
        .saida(saida1), .ocupado(ocupado1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: row l, output byte k takes input byte (k +/- (l mod nc)) mod nc.
    function automatic logic [127:0] modelo(input logic [127:0] b, input logic inv,
                                            input int nl, input int nc);
        logic [127:0] r;
        int s;
        int src;
        r = b;
        for (int l = 0; l < nl; l++) begin
            s = l % nc;
            for (int k = 0; k < nc; k++) begin
                src = inv ? (k - s + nc) % nc : (k + s) % nc;
                r[127 - (l*nc + k)*8 -: 8] = b[127 - (l*nc + src)*8 -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic modo_efetivo(input logic m);
`ifdef ROTACIONA_INVERSA_EN
        return m;
`else
        return 1'b0 & m;
`endif
    endfunction

    task automatic cmp_bit(input string nome, input int id, input logic a, input logic e);
        testes++;
        if (a !== e) begin
            falhas++;
            $display("FAIL %s dut%0d cyc=%0d: got %b, expected %b", nome, id, cyc, a, e);
        end
    endtask

    task automatic cmp_vet(input string nome, input int id, input logic [127:0] a,
                           input logic [127:0] e);
        testes++;
        if (a !== e) begin
            falhas++;
            $display("FAIL %s dut%0d cyc=%0d: got %h, expected %h", nome, id, cyc, a, e);
        end
    endtask

    task automatic cmp_int(input string nome, input int id, input int a, input int e);
        testes++;
        if (a != e) begin
            falhas++;
            $display("FAIL %s dut%0d cyc=%0d: got %0d, expected %0d", nome, id, cyc, a, e);
        end
    endtask

    // Transaction-level model: at most one block held, ready at a known edge.
    bit           modelo_ok = 1'b0;
    bit           tem[2];
    logic [127:0] item[2];
    logic [127:0] ultimo[2];
    int           pronto_em[2];
    int           acc_ult[2];
    int           acc_pen[2];
    int           acc_cnt[2];
    logic [127:0] entregue_ult[2];
    logic [127:0] entregue_pen[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            tem[i] = 1'b0; item[i] = '0; ultimo[i] = '0; pronto_em[i] = 0;
            acc_ult[i] = 0; acc_pen[i] = 0; acc_cnt[i] = 0;
            entregue_ult[i] = '0; entregue_pen[i] = '0;
        end
    end

    task automatic verifica(input int id, input logic sv, input logic [127:0] s,
                            input logic ep, input logic oc);
        int nl;
        int nc;
        logic ev;
        nl = (id == 0) ? 4 : 2;
        nc = (id == 0) ? 4 : 8;
        ev = tem[id] && (cyc >= pronto_em[id]);
        if (modelo_ok) begin
            cmp_bit("saida_valida", id, sv, ev);
            cmp_vet("saida", id, s, ev ? item[id] : ultimo[id]);
            cmp_bit("entrada_pronta", id, ep, rst_n && !tem[id]);
            cmp_bit("ocupado", id, oc, tem[id]);
        end
        if (!rst_n) begin
            tem[id] = 1'b0;
            ultimo[id] = '0;
        end else if (ev && saida_pronta) begin
            tem[id] = 1'b0;
            ultimo[id] = item[id];
            entregue_pen[id] = entregue_ult[id];
            entregue_ult[id] = s;
        end else if (!tem[id] && entrada_valida) begin
            tem[id] = 1'b1;
            item[id] = modelo(bloco, modo_efetivo(modo), nl, nc);
            pronto_em[id] = cyc + nl;
            acc_pen[id] = acc_ult[id];
            acc_ult[id] = cyc + 1;
            acc_cnt[id]++;
        end
    endtask

    always @(negedge clk) begin
        verifica(0, saida_valida0, saida0, entrada_pronta0, ocupado0);
        verifica(1, saida_valida1, saida1, entrada_pronta1, ocupado1);
        if (!rst_n) modelo_ok = 1'b1;
    end

    task automatic espera_borda();
        @(posedge clk);
        #1;
    endtask

    task automatic envia(input logic [127:0] b, input logic m);
        bit ok;
        ok = 1'b0;
        bloco = b;
        modo = m;
        entrada_valida = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = entrada_pronta0;
            espera_borda();
        end
        entrada_valida = 1'b0;
        cmp_bit("envia_aceite", 0, ok, 1'b1);
    endtask

    task automatic ocioso();
        bit ok;
        ok = 1'b0;
        saida_pronta = 1'b1;
        entrada_valida = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            espera_borda();
            ok = entrada_pronta0 && entrada_pronta1;
        end
        cmp_bit("espera_ocioso", 0, ok, 1'b1);
    endtask

    logic [127:0] s0;
    logic [127:0] bloco_a;
    logic [127:0] bloco_b;
    int           base0;
    int           base1;
    bit           ok_w;

    initial begin
        // Pin the reference model with hand-computed vectors.
        cmp_vet("modelo_v1", 0, modelo(V1, 1'b0, 4, 4), L1);
        cmp_vet("modelo_v5", 1, modelo(V5, 1'b0, 2, 8), L5);
        cmp_vet("modelo_inv", 0, modelo(L1, 1'b1, 4, 4), V1);

        rst_n = 1'b0;
        repeat (3) espera_borda();
        cmp_bit("reset_saida_valida", 0, saida_valida0, 1'b0);
        cmp_vet("reset_saida", 0, saida0, '0);
        cmp_bit("reset_ocupado", 0, ocupado0, 1'b0);
        cmp_bit("reset_entrada_pronta", 0, entrada_pronta0, 1'b0);
        rst_n = 1'b1;
        #1;
        cmp_bit("pos_reset_entrada_pronta", 0, entrada_pronta0, 1'b1);
        espera_borda();

        // Forward vector, latency of 3 edges.
        envia(V1, 1'b0);
        cmp_bit("t1_lat0", 0, saida_valida0, 1'b0);
        repeat (2) espera_borda();
        cmp_bit("t1_lat2", 0, saida_valida0, 1'b0);
        espera_borda();
        cmp_bit("t1_lat3", 0, saida_valida0, 1'b1);
        cmp_vet("t1_saida", 0, saida0, L1);

        // Two-row instance, latency of 1 edge.
        ocioso();
        envia(V5, 1'b0);
        cmp_bit("t5_lat0", 1, saida_valida1, 1'b0);
        espera_borda();
        cmp_bit("t5_lat1", 1, saida_valida1, 1'b1);
        cmp_vet("t5_saida", 1, saida1, L5);

        // Inverse mode (left rotation when the feature is compiled out).
        ocioso();
        envia(L1, 1'b1);
        repeat (3) espera_borda();
        cmp_bit("t2_valida", 0, saida_valida0, 1'b1);
`ifdef ROTACIONA_INVERSA_EN
        cmp_vet("t2_saida", 0, saida0, V1);
`else
        cmp_vet("t2_saida", 0, saida0, modelo(L1, 1'b0, 4, 4));
`endif

        // Backpressure with an ignored input pulse.
        ocioso();
        saida_pronta = 1'b0;
        envia(V1, 1'b0);
        ok_w = 1'b0;
        for (int i = 0; i < 20 && !ok_w; i++) begin
            if (saida_valida0) ok_w = 1'b1;
            else espera_borda();
        end
        cmp_bit("t3_espera_valida", 0, ok_w, 1'b1);
        s0 = saida0;
        cmp_vet("t3_saida", 0, s0, L1);
        for (int i = 0; i < 5; i++) begin
            bloco = {$urandom, $urandom, $urandom, $urandom};
            entrada_valida = i[0] ? 1'b0 : 1'b1;
            espera_borda();
            cmp_vet("t3_saida_estavel", 0, saida0, s0);
            cmp_bit("t3_valida_estavel", 0, saida_valida0, 1'b1);
            cmp_bit("t3_sem_aceite", 0, entrada_pronta0, 1'b0);
        end
        entrada_valida = 1'b0;
        saida_pronta = 1'b1;
        espera_borda();
        cmp_bit("t3_volta_ocioso", 0, entrada_pronta0, 1'b1);
        cmp_bit("t3_valida_baixa", 0, saida_valida0, 1'b0);
        cmp_vet("t3_saida_mantida", 0, saida0, s0);

        // Reset in the second rotation cycle.
        ocioso();
        envia(V1, 1'b0);
        espera_borda();
        rst_n = 1'b0;
        espera_borda();
        cmp_bit("t4_valida", 0, saida_valida0, 1'b0);
        cmp_vet("t4_saida", 0, saida0, '0);
        cmp_bit("t4_ocupado", 0, ocupado0, 1'b0);
        rst_n = 1'b1;
        #1;
        cmp_bit("t4_entrada_pronta", 0, entrada_pronta0, 1'b1);
        envia(V1, 1'b0);
        repeat (3) espera_borda();
        cmp_bit("t4_valida_apos", 0, saida_valida0, 1'b1);
        cmp_vet("t4_saida_apos", 0, saida0, L1);

        // Streaming with entrada_valida held high.
        ocioso();
        base0 = acc_cnt[0];
        base1 = acc_cnt[1];
        bloco_a = {$urandom, $urandom, $urandom, $urandom};
        bloco_b = ~bloco_a;
        bloco = bloco_a;
        modo = 1'b0;
        entrada_valida = 1'b1;
        ok_w = 1'b0;
        for (int i = 0; i < 20 && !ok_w; i++) begin
            espera_borda();
            ok_w = (acc_cnt[0] > base0);
        end
        bloco = bloco_b;
        ok_w = 1'b0;
        for (int i = 0; i < 20 && !ok_w; i++) begin
            espera_borda();
            ok_w = (acc_cnt[0] >= base0 + 2);
        end
        entrada_valida = 1'b0;
        cmp_bit("t6_dois_aceites", 0, ok_w, 1'b1);
        cmp_int("t6_espacamento", 0, acc_ult[0] - acc_pen[0], 5);
        cmp_bit("t6_dois_aceites", 1, acc_cnt[1] >= base1 + 2, 1'b1);
        cmp_int("t6_espacamento", 1, acc_ult[1] - acc_pen[1], 3);
        repeat (8) espera_borda();
        cmp_vet("t6_primeiro", 0, entregue_pen[0], modelo(bloco_a, 1'b0, 4, 4));
        cmp_vet("t6_segundo", 0, entregue_ult[0], modelo(bloco_b, 1'b0, 4, 4));

        // Random traffic, checked every cycle by the model.
        for (int i = 0; i < 400; i++) begin
            bloco = {$urandom, $urandom, $urandom, $urandom};
            modo = 1'($urandom_range(0, 1));
            entrada_valida = 1'($urandom_range(0, 1));
            saida_pronta = ($urandom_range(0, 2) != 0);
            rst_n = ($urandom_range(0, 49) != 0);
            espera_borda();
        end
        rst_n = 1'b1;
        entrada_valida = 1'b0;
        saida_pronta = 1'b1;
        repeat (10) espera_borda();

        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

endmodule
